load_store_unit: RTL

//  MEM-stage initiator for data memory. Takes one load/store per instruction from the pipeline
//  (RISC-V func3 encoding), drives a word-aligned, byte-enabled memory port with a req/ack

---
 rtl/load_store_unit_pkg.sv | 54 +++++
 rtl/load_store_unit_align.sv | 57 +++++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module : load_store_unit_pkg
//  Brief  : Shared constants for the load/store unit. Holds the RISC-V func3
//           codes, the FSM state encodings and the access-size helpers used
//           by both the top level and the alignment datapath.
//  Rev    : 1.0  initial release
// ============================================================================
package load_store_unit_pkg;

    // RISC-V load/store func3 encodings
    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    // FSM state encodings
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BEAT0 = 2'd1;
    localparam logic [1:0] c_ST_BEAT1 = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    // Byte-lane mask for an access, before shifting by the address offset.
    function automatic logic [3:0] f_size_mask(input logic [1:0] i_sz);
        case (i_sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Access size in bytes (1, 2 or 4).
    function automatic logic [2:0] f_size_bytes(input logic [1:0] i_sz);
        case (i_sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Stores only exist as B/H/W; loads additionally allow BU/HU.
    function automatic logic f_func3_legal(input logic i_write, input logic [2:0] i_f3);
        case (i_f3)
            c_F3_B, c_F3_H, c_F3_W: return 1'b1;
            c_F3_BU, c_F3_HU:       return ~i_write;
            default:                return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
//  Module : lsu_align
//  Brief  : Combinational alignment datapath. Produces the 8-bit byte-enable
//           and 64-bit write-data images spanning two words, flags accesses
//           that cross a word boundary, and shifts/extends the read data.
//  Ports  : i_func3   access type (RISC-V func3)
//           i_off     byte offset within the word (addr[1:0])
//           i_wdata   LSB-justified store data
//           i_rdata0  first-beat read word, i_rdata1 second-beat read word
//           o_two_beat  access spans two words
//           o_be64    byte enables, [3:0] beat0 / [7:4] beat1
//           o_wd64    lane-shifted write data, [31:0] beat0 / [63:32] beat1
//           o_ld_data sign/zero-extended load result
//  Rev    : 1.0  initial release
// ============================================================================
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata0,
    input  logic [31:0] i_rdata1,
    output logic        o_two_beat,
    output logic [7:0]  o_be64,
    output logic [63:0] o_wd64,
    output logic [31:0] o_ld_data
);

    logic [2:0]  w_size;
    logic [4:0]  w_shamt;
    logic [31:0] w_rd;

    assign w_size  = f_size_bytes(i_func3[1:0]);
    assign w_shamt = {i_off, 3'b000};

    // off + size fits in 3 bits (max 3 + 4 = 7)
    assign o_two_beat = (({1'b0, i_off} + w_size) > 3'd4);
    assign o_be64     = {4'b0000, f_size_mask(i_func3[1:0])} << i_off;
    assign o_wd64     = {32'h0, i_wdata} << w_shamt;

    // Only the low word of the shifted two-word image is ever needed
    assign w_rd = 32'({i_rdata1, i_rdata0} >> w_shamt);

    always_comb begin
        case (i_func3)
            c_F3_B:  o_ld_data = {{24{w_rd[7]}}, w_rd[7:0]};
            c_F3_H:  o_ld_data = {{16{w_rd[15]}}, w_rd[15:0]};
            c_F3_BU: o_ld_data = {24'h0, w_rd[7:0]};
            c_F3_HU: o_ld_data = {16'h0, w_rd[15:0]};
            default: o_ld_data = w_rd;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module : load_store_unit
//  Brief  : MEM-stage data-memory initiator. Latches one load/store, runs one
//           or two word-aligned req/ack beats (two when the access crosses a
//           word boundary), and returns extended load data with a one-cycle
//           response pulse. The pipeline is stalled until the response.
//  Ports  : clk, rst (async, active-high)
//           req_valid/req_write/req_func3/req_addr/req_wdata  pipeline request
//           stall                                              pipeline hold
//           resp_valid/resp_data/resp_err                      completion
//           mem_req/mem_we/mem_addr/mem_be/mem_wdata           memory beat
//           mem_rdata/mem_ack                                  memory reply
//  Rev    : 1.0  initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ACK_TO = 0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned        c_CNT_W    = (ACK_TO > 1) ? $clog2(ACK_TO + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LIMIT = c_CNT_W'(ACK_TO);

    logic [1:0]         r_state;
    logic               r_write;
    logic [2:0]         r_func3;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata0;
    logic [31:0]        r_rdata1;
    logic               r_err;
    logic [c_CNT_W-1:0] r_to_cnt;

    logic               w_legal;
    logic               w_timeout;
    logic               w_in_beat;
    logic               w_two_beat;
    logic [7:0]         w_be64;
    logic [63:0]        w_wd64;
    logic [31:0]        w_ld_data;
    logic [ADDR_W-1:0]  w_base;
    logic [ADDR_W-1:0]  w_next;

    lsu_align u_align (
        .i_func3    (r_func3),
        .i_off      (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_rdata0   (r_rdata0),
        .i_rdata1   (r_rdata1),
        .o_two_beat (w_two_beat),
        .o_be64     (w_be64),
        .o_wd64     (w_wd64),
        .o_ld_data  (w_ld_data)
    );

    assign w_legal   = f_func3_legal(req_write, req_func3);
    // A zero limit disables the timeout entirely; an ack in the limit cycle still wins
    assign w_timeout = (ACK_TO != 0) && (r_to_cnt == c_TO_LIMIT);
    assign w_in_beat = (r_state == c_ST_BEAT0) || (r_state == c_ST_BEAT1);
    assign w_base    = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_next    = w_base + ADDR_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_write  <= 1'b0;
            r_func3  <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_rdata0 <= 32'h0;
            r_rdata1 <= 32'h0;
            r_err    <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_func3  <= req_func3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_rdata0 <= 32'h0;
                        r_rdata1 <= 32'h0;
                        r_err    <= ~w_legal;
                        r_to_cnt <= '0;
                        // Illegal encodings never touch memory
                        r_state  <= w_legal ? c_ST_BEAT0 : c_ST_RESP;
                    end
                end
                c_ST_BEAT0: begin
                    if (mem_ack) begin
                        r_rdata0 <= mem_rdata;
                        r_to_cnt <= '0;
                        r_state  <= w_two_beat ? c_ST_BEAT1 : c_ST_RESP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_BEAT1: begin
                    if (mem_ack) begin
                        r_rdata1 <= mem_rdata;
                        r_state  <= c_ST_RESP;
                    end else if (w_timeout) begin
                        // A first store beat already written stays written
                        r_err   <= 1'b1;
                        r_state <= c_ST_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_CNT_W'(1);
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        if (r_state == c_ST_BEAT0) begin
            mem_addr  = w_base;
            mem_be    = w_be64[3:0];
            mem_wdata = w_wd64[31:0];
        end else if (r_state == c_ST_BEAT1) begin
            mem_addr  = w_next;
            mem_be    = w_be64[7:4];
            mem_wdata = w_wd64[63:32];
        end
    end

    assign mem_req    = w_in_beat;
    assign mem_we     = w_in_beat & r_write;
    assign stall      = ((r_state == c_ST_IDLE) & req_valid) | w_in_beat;
    assign resp_valid = (r_state == c_ST_RESP);
    assign resp_err   = (r_state == c_ST_RESP) & r_err;
    assign resp_data  = ((r_state == c_ST_RESP) & ~r_err & ~r_write) ? w_ld_data : 32'h0;

endmodule
`default_nettype wire
